// File: rtl/mul_seq.sv
// mul_seq: sequential RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// It computes one radix-2 shift-add step per cycle on magnitudes and
// applies the sign at the end.
// Fixed latency: start sampled in cycle N gives done in cycle N+34.
// Optional build macro MUL_SEQ_EARLY_EXIT_EN: RUN ends as soon as the
// remaining multiplier bits are zero. The accumulator is then realigned
// in one cycle, so results match the fixed-latency build bit for bit.

// cla32: 32-bit adder built from 4-bit carry-lookahead groups.
// The group carries are chained.
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] p;
  logic [31:0] g;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;

  assign p = a ^ b;
  assign g = a & b;

  // Group generate/propagate, group carry chain, then per-bit carries inside each group
  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    gc[0] = cin;
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[8];
endmodule

module mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [1:0]          op_q;
  logic                neg_q;
  logic [DATA_W-1:0]   mcand_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   result_q;
  logic                done_q;

  // Magnitude of a possibly signed operand.
  // The most negative value maps to 2^31, which still fits in 32 unsigned bits.
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v,
                                            input logic is_signed);
    logic signed [DATA_W-1:0] n;
    n = -v;
    if (is_signed && v[DATA_W-1]) return n;
    return v;
  endfunction

  // Conditional two's-complement negation of the full 64-bit product
  function automatic logic [2*DATA_W-1:0] neg64(input logic [2*DATA_W-1:0] v,
                                                input logic en);
    if (en) return ~v + 64'd1;
    return v;
  endfunction

  // Operand decode at the accepting edge
  logic              rs1_signed;
  logic              rs2_signed;
  logic              neg_in;
  logic [DATA_W-1:0] mcand_in;
  logic [DATA_W-1:0] mplr_in;

  assign rs1_signed = (op == OP_MULH) || (op == OP_MULHSU);
  assign rs2_signed = (op == OP_MULH);
  assign neg_in     = (rs1_signed & rs1[DATA_W-1]) ^ (rs2_signed & rs2[DATA_W-1]);
  assign mcand_in   = mag(rs1, rs1_signed);
  assign mplr_in    = mag(rs2, rs2_signed);

  // One shift-add iteration: conditional add into hi, then {cout,hi,lo} >> 1
  logic [DATA_W-1:0]   add_sum;
  logic                add_cout;
  logic [DATA_W-1:0]   step_hi;
  logic                step_c;
  logic [2*DATA_W-1:0] shifted;
  logic                last_iter;
  logic [2*DATA_W-1:0] acc_fin;

  cla32 u_add (
    .a    (hi_q),
    .b    (mcand_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign step_hi   = lo_q[0] ? add_sum : hi_q;
  assign step_c    = lo_q[0] & add_cout;
  assign shifted   = {step_c, step_hi, lo_q[DATA_W-1:1]};
  assign last_iter = (cnt_q == 6'd31);
  assign acc_fin   = neg64({hi_q, lo_q}, neg_q);

`ifdef MUL_SEQ_EARLY_EXIT_EN
  // mrem_q holds the multiplier bits not yet consumed.
  // Once they are all zero, the remaining iterations would only shift.
  logic [DATA_W-1:0]   mrem_q;
  logic [DATA_W-1:0]   mrem_next;
  logic                early;
  logic [CNT_W-1:0]    rem_cnt;
  logic [2*DATA_W-1:0] aligned;
  logic                idle_zero;

  assign mrem_next = mrem_q >> 1;
  assign early     = (mrem_next == '0);
  assign rem_cnt   = 6'd31 - cnt_q;
  assign aligned   = shifted >> rem_cnt;
  assign idle_zero = (mplr_in == '0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and busy decode
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MUL_SEQ_EARLY_EXIT_EN
          state_d = idle_zero ? FIN : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN: begin
`ifdef MUL_SEQ_EARLY_EXIT_EN
        if (last_iter || early) state_d = FIN;
`else
        if (last_iter) state_d = FIN;
`endif
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, accumulator iteration, final sign fix-up and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
      mrem_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            neg_q   <= neg_in;
            mcand_q <= mcand_in;
            hi_q    <= '0;
            lo_q    <= mplr_in;
            cnt_q   <= '0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
            mrem_q  <= mplr_in;
`endif
          end
        end
        RUN: begin
`ifdef MUL_SEQ_EARLY_EXIT_EN
          {hi_q, lo_q} <= early ? aligned : shifted;
          mrem_q       <= mrem_next;
`else
          {hi_q, lo_q} <= shifted;
`endif
          cnt_q <= cnt_q + 6'd1;
        end
        FIN: begin
          result_q <= (op_q == OP_MUL) ? acc_fin[DATA_W-1:0] : acc_fin[2*DATA_W-1:DATA_W];
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done   = done_q;
  assign result = result_q;
endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock; all state changes on this edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset, sampled on clk.
REQ-003 SHALL have ports: start  input  1  request pulse; sampled only in IDLE.
REQ-004 SHALL have ports: op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (RV32M funct3[1:0]).
REQ-005 SHALL have ports: rs1  input  32  multiplicand; signed for MULH and MULHSU.
REQ-006 SHALL have ports: rs2  input  32  multiplier; signed for MULH only.
REQ-007 SHALL have ports: busy  output  1  high from the cycle after start is accepted until done.
REQ-008 SHALL have ports: done  output  1  one-cycle pulse when result is valid.
REQ-009 SHALL have ports: result  output  32  low product word (MUL) or high product word (other ops); held until the next accepted start.

Function
REQ-010 SHALL implement states IDLE, RUN and FIN.
REQ-011 IDLE -> RUN SHALL occur when start=1 in IDLE; rs1, rs2 and op SHALL be latched at that edge.
REQ-012 On entry to RUN, the latched operands SHALL be converted to magnitudes; a negate flag SHALL be computed as sign(rs1) XOR sign(rs2), with each sign counting only when that operand is signed for op.
REQ-013 Each RUN cycle SHALL perform one shift-add iteration on a 64-bit accumulator {hi, lo}, with lo initialised to |rs2| and hi to 0.
REQ-014 In each iteration, if lo[0]=1 then hi SHALL be replaced by hi + |rs1|, using the team cla32 adder instance, including its cout.
REQ-015 After the add step of each iteration, {cout, hi, lo} SHALL be shifted right by 1.
REQ-016 RUN SHALL last exactly 32 cycles, counted by a 6-bit iteration counter; the last iteration SHALL transition to FIN.
REQ-017 In FIN, the 64-bit accumulator SHALL be two's-complement negated if the negate flag is set, result SHALL be loaded with the low or high word per op, and the state SHALL return to IDLE.
REQ-018 done SHALL be high in exactly the cycle following FIN, with result valid in that same cycle; fixed latency is start sampled in cycle N -> done in cycle N+34.
REQ-019 start while busy SHALL be ignored, with no queueing and no effect on the operation in flight.
REQ-020 start asserted in the cycle where done=1 SHALL be accepted as a new operation.
REQ-021 Operand magnitude of 0x80000000 SHALL be handled as the unsigned value 2^31, with no overflow.

Reset
REQ-022 When reset=1, the block SHALL go to IDLE and set busy=0, done=0, result=0x00000000, and clear the accumulator and counter on that edge, including mid-RUN or in FIN.
REQ-023 reset SHALL take priority over start in the same cycle.

Configuration
REQ-024 Macro MUL_SEQ_EARLY_EXIT_EN, when defined, SHALL make RUN go to FIN as soon as the remaining unshifted multiplier bits are all zero.
REQ-025 When MUL_SEQ_EARLY_EXIT_EN is defined, the accumulator SHALL be aligned by shifting right by the remaining iteration count in one cycle, and result values SHALL be bit-identical to the fixed-latency build.
REQ-026 When MUL_SEQ_EARLY_EXIT_EN is defined, latency SHALL be at most 34 cycles; with rs2=0 it SHALL be 2 cycles (start in N -> done in N+2).
REQ-027 When MUL_SEQ_EARLY_EXIT_EN is undefined, latency SHALL be fixed at 34 cycles for all operands.

Verification
REQ-028 A bench SHALL cover: MUL rs1=0x00000007, rs2=0x00000006 -> result=0x0000002A, done in cycle N+34.
REQ-029 A bench SHALL cover: MULH rs1=0x80000000, rs2=0xFFFFFFFF -> result=0x00000000; the same operands with MUL -> 0x80000000.
REQ-030 A bench SHALL cover: MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU with the same operands -> 0xFFFFFFFF.
REQ-031 A bench SHALL cover: start pulsed at cycles N+5 and N+20 during busy -> ignored, with exactly one done and result for the first operands only.
REQ-032 A bench SHALL cover: reset asserted in cycle N+15 of a MUL -> next cycle busy=0, done=0, result=0; a start two cycles later completes normally.
REQ-033 A bench SHALL cover, with MUL_SEQ_EARLY_EXIT_EN defined: MULHU rs2=0x00000001, rs1=0x12345678 -> result=0x00000000, done no later than N+34, value matching the non-macro build.
